pipe_stage_buf: RTL
===================

Name: pipe_stage_buf

Overview:
- Generic, parametrised pipeline-stage register for the MIPS pipeline. Replaces the hand-written per-stage registers.
- Carries a control-signal bundle and a data bundle. Uses a valid/ready handshake with a 2-entry skid buffer, so a downstream stall does not combinationally propagate upstream.
- Flush turns both entries into bubbles (all-zero control).
- Counts entries discarded by flush, for branch/jump debug.

Parameters:
- CTRL_W, 17: width of control bundle (WB/MEM/EX signals); all-zero = bubble/NOP.
- DATA_W, 128: width of data bundle (PC+4, operands, register addresses, etc. concatenated by the wrapper).
- CNT_W, 8: width of the saturating flush-drop counter.

Ports:
- sysclk, input, 1: clock, all state changes on rising edge.
- reset, input, 1: synchronous, active-low reset.
- flush, input, 1: discard all held entries; next cycle is a bubble.
- in_valid, input, 1: upstream holds a valid entry.
- in_ready, output, 1: stage can accept an entry this cycle.
- in_ctrl, input, CTRL_W: upstream control bundle.
- in_data, input, DATA_W: upstream data bundle.
- out_valid, output, 1: out_ctrl/out_data hold a valid entry.
- out_ready, input, 1: downstream accepts the entry this cycle.
- out_ctrl, output, CTRL_W: control bundle; forced all-zero whenever out_valid=0.
- out_data, output, DATA_W: data bundle; holds last value when out_valid=0.
- occupancy, output, 2: number of held entries (0, 1 or 2).
- drop_cnt, output, CNT_W: saturating count of valid entries discarded by flush.

Behaviour:
- Storage: main register (drives outputs), skid register, 2-bit state.
- States: EMPTY (0 entries), FULL (main valid), SKID (main and skid valid).
- Reset (sampled on a rising edge with reset=0):
  - State goes to EMPTY; main, skid and drop_cnt clear to 0.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready is gated to 0 while reset=0.
  - Reset mid-operation discards all entries silently; drop_cnt is not incremented.
- Handshakes: accept = in_valid & in_ready; issue = out_valid & out_ready.
- in_ready = (state != SKID) & reset. It is decoded from registered state only, never from out_ready.
- Latency: an accepted entry appears on the outputs the next cycle. Throughput is 1 entry/cycle when out_ready=1.
- Transitions (flush=0):
  - EMPTY: accept -> FULL, main<=in. Otherwise stay EMPTY.
  - FULL, issue & accept -> FULL, main<=in.
  - FULL, issue & !accept -> EMPTY.
  - FULL, !out_ready & accept -> SKID, skid<=in.
  - FULL, !out_ready & !accept -> hold.
  - SKID: issue -> FULL, main<=skid. Otherwise hold. No accept is possible in SKID.
- Ordering: entries leave in acceptance order; the skid entry is never overtaken.
- Flush (highest priority below reset):
  - Next state is EMPTY. Main/skid control fields are cleared to 0; data fields are kept.
  - An input offered in the flush cycle is not captured, even though in_ready may be 1. Upstream must treat it as squashed.
  - Issue in the flush cycle still counts as delivered downstream.
  - drop_cnt += number of held valid entries not issued that cycle: 0, 1 or 2.
- drop_cnt saturates at 2^CNT_W-1 and never wraps.
- occupancy = 0, 1, 2 for EMPTY, FULL, SKID.
- Illegal state encoding recovers to EMPTY on the next edge.
- out_ctrl zero-forcing is combinational on out_valid. Downstream control sees NOP during bubbles regardless of stale main contents.

Decomposition:
- Shared package pipe_pkg:
  - State localparams ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2.
  - Per-stage CTRL_W/DATA_W constants for the IF/ID, ID/EX, EX/MEM and MEM/WB instances.
  - Control bundle field offsets: WB [16:14], MEM [13:12], EX [11:0].
- No sub-module. The block is one FSM plus two entry registers. Stage wrappers only concatenate fields and instantiate pipe_stage_buf.

Test Plan:
- Reset: hold reset=0 two cycles with in_valid=1 -> in_ready=0, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, drop_cnt=0. Release -> in_ready=1.
- Streaming: out_ready=1, feed in_data=1..8 with in_ctrl=17'h1ABCD on consecutive cycles -> out_data=1..8 on cycles 1..8 after each accept, out_valid continuous, occupancy=1.
- Stall/skid: out_ready=0 while sending A=0x11, B=0x22, C=0x33 -> A, B accepted; occupancy reaches 2; in_ready=0 so C is held upstream. Raise out_ready -> A, B, C delivered in order, no loss, no duplication.
- Flush in SKID with out_ready=0 and in_valid=1 (D) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, drop_cnt +2, D not captured.
- Flush in FULL with out_ready=1 -> issued entry counted as delivered, drop_cnt unchanged, state EMPTY.
- Saturation: CNT_W=2, repeat the SKID flush 3 times -> drop_cnt = 2, 3, 3.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the MIPS pipeline-stage registers: state encoding,
// per-stage bundle widths and the field layout of the control bundle.
package pipe_pkg;

  // Buffer state: how many entries the stage is holding.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stateT;

  // IF/ID carries no control, only PC+4 and the fetched instruction.
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  // ID/EX carries the full WB/MEM/EX control set plus operands and register addresses.
  localparam int IDEX_CTRL_W  = 17;
  localparam int IDEX_DATA_W  = 128;
  // EX/MEM keeps only WB and MEM control; ALU result, store data, destination, zero flag.
  localparam int EXMEM_CTRL_W = 5;
  localparam int EXMEM_DATA_W = 70;
  // MEM/WB keeps only WB control; load data, ALU result, destination.
  localparam int MEMWB_CTRL_W = 3;
  localparam int MEMWB_DATA_W = 69;

  // Control bundle field positions (full 17-bit layout).
  localparam int CTRL_WB_HI  = 16;
  localparam int CTRL_WB_LO  = 14;
  localparam int CTRL_MEM_HI = 13;
  localparam int CTRL_MEM_LO = 12;
  localparam int CTRL_EX_HI  = 11;
  localparam int CTRL_EX_LO  = 0;

  // Number of entries held in a given state; an illegal encoding holds nothing.
  function automatic logic [1:0] stateOccupancy(input stateT s);
    case (s)
      ST_FULL: return 2'd1;
      ST_SKID: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline-stage register with a valid/ready handshake and a
// two-entry skid buffer. in_ready depends only on registered state, so a
// downstream stall never ripples combinationally upstream. Flush squashes
// everything held and counts the discarded valid entries.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int DATA_W = IDEX_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  stateT             state, stateNext;
  logic [CTRL_W-1:0] mainCtrl, mainCtrlNext;
  logic [DATA_W-1:0] mainData, mainDataNext;
  logic [CTRL_W-1:0] skidCtrl, skidCtrlNext;
  logic [DATA_W-1:0] skidData, skidDataNext;
  logic [CNT_W-1:0]  dropCnt, dropCntNext;
  logic              accept;
  logic              issue;
  logic [1:0]        dropInc;
  logic [CNT_W:0]    dropSum;

  // Output-side decode from registered state; bubbles present an all-zero control bundle.
  always_comb begin
    occupancy = stateOccupancy(state);
    out_valid = (state == ST_FULL) || (state == ST_SKID);
    in_ready  = (state != ST_SKID) && reset;
    out_ctrl  = out_valid ? mainCtrl : '0;
    out_data  = mainData;
    drop_cnt  = dropCnt;
    accept    = in_valid && in_ready;
    issue     = out_valid && out_ready;
  end

  // Next-state, entry movement and saturating drop count.
  always_comb begin
    stateNext    = state;
    mainCtrlNext = mainCtrl;
    mainDataNext = mainData;
    skidCtrlNext = skidCtrl;
    skidDataNext = skidData;
    dropCntNext  = dropCnt;
    dropInc      = occupancy - {1'b0, issue};
    dropSum      = {1'b0, dropCnt} + {{(CNT_W-1){1'b0}}, dropInc};

    if (flush) begin
      stateNext    = ST_EMPTY;
      mainCtrlNext = '0;
      skidCtrlNext = '0;
      dropCntNext  = dropSum[CNT_W] ? {CNT_W{1'b1}} : dropSum[CNT_W-1:0];
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            stateNext    = ST_FULL;
            mainCtrlNext = in_ctrl;
            mainDataNext = in_data;
          end
        end
        ST_FULL: begin
          if (issue && accept) begin
            mainCtrlNext = in_ctrl;
            mainDataNext = in_data;
          end else if (issue) begin
            stateNext = ST_EMPTY;
          end else if (accept) begin
            stateNext    = ST_SKID;
            skidCtrlNext = in_ctrl;
            skidDataNext = in_data;
          end
        end
        ST_SKID: begin
          if (issue) begin
            stateNext    = ST_FULL;
            mainCtrlNext = skidCtrl;
            mainDataNext = skidData;
          end
        end
        default: stateNext = ST_EMPTY;
      endcase
    end
  end

  // State and entry registers with synchronous active-low reset.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state    <= ST_EMPTY;
      mainCtrl <= '0;
      mainData <= '0;
      skidCtrl <= '0;
      skidData <= '0;
      dropCnt  <= '0;
    end else begin
      state    <= stateNext;
      mainCtrl <= mainCtrlNext;
      mainData <= mainDataNext;
      skidCtrl <= skidCtrlNext;
      skidData <= skidDataNext;
      dropCnt  <= dropCntNext;
    end
  end

endmodule
